// File: rtl/ad3542_spi_responder_if.sv
// Bus bundle between the AD3542 SPI initiator side and the responder:
// SPI pins plus ldac in one direction, decoded DAC codes and register writes in the other.
interface ad3542_spi_responder_if;
  logic        spi_sclk;
  logic        spi_cs;
  logic        spi_sdio0;
  logic        spi_sdio1;
  logic        ldac;
  logic [15:0] dac_0;
  logic [15:0] dac_1;
  logic        dac_update;
  logic [6:0]  reg_addr;
  logic [7:0]  reg_data;
  logic        reg_valid;
  logic        frame_err;
  logic [15:0] frame_count;

  modport master (
    output spi_sclk, spi_cs, spi_sdio0, spi_sdio1, ldac,
    input  dac_0, dac_1, dac_update,
    input  reg_addr, reg_data, reg_valid,
    input  frame_err, frame_count
  );

  modport slave (
    input  spi_sclk, spi_cs, spi_sdio0, spi_sdio1, ldac,
    output dac_0, dac_1, dac_update,
    output reg_addr, reg_data, reg_valid,
    output frame_err, frame_count
  );
endinterface

// File: rtl/ad3542_spi_responder.sv
// Oversampled AD3542 write-stream decoder: single-lane instruction, dual-lane data,
// staged DAC words committed on clean cs rise and loaded to outputs on ldac fall.
module ad3542_spi_responder #(
  parameter logic [6:0] DAC_ADDR = 7'h2A,
  parameter int         SYNC_STG = 2
) (
  input logic                   clk,
  input logic                   reset,
  ad3542_spi_responder_if.slave bus
);
  localparam int C = SYNC_STG - 2;
  localparam int P = SYNC_STG - 1;

  typedef enum logic [2:0] {
    WAIT_CS, IDLE, INSTR, DATA_DAC, DATA_REG, IGNORE
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STG-1:0] sclk_q, cs_q, d0_q, d1_q, ldac_q;

  // cs resets to "selected" so a frame running through reset is never seen as a fresh cs fall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q <= '0;
      cs_q   <= '0;
      d0_q   <= '0;
      d1_q   <= '0;
      ldac_q <= '1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STG-2:0], bus.spi_sclk};
      cs_q   <= {cs_q[SYNC_STG-2:0], bus.spi_cs};
      d0_q   <= {d0_q[SYNC_STG-2:0], bus.spi_sdio0};
      d1_q   <= {d1_q[SYNC_STG-2:0], bus.spi_sdio1};
      ldac_q <= {ldac_q[SYNC_STG-2:0], bus.ldac};
    end
  end

  logic sclk_rise, cs_rise, cs_fall, cs_hi, ldac_fall;
  logic sdio0, sdio1;

  assign sclk_rise = sclk_q[C] & ~sclk_q[P];
  assign cs_rise   = cs_q[C] & ~cs_q[P];
  assign cs_fall   = ~cs_q[C] & cs_q[P];
  assign cs_hi     = cs_q[C];
  assign ldac_fall = ~ldac_q[C] & ldac_q[P];
  assign sdio0     = d0_q[P];
  assign sdio1     = d1_q[P];

  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  word_cnt_q, word_cnt_d;
  logic [7:0]  instr_q, instr_d, instr_nx;
  logic [15:0] shift_q, shift_d, shift_nx;
  logic [15:0] stage0_q, stage0_d, stage1_q, stage1_d;
  logic [15:0] shadow0_q, shadow0_d, shadow1_q, shadow1_d;
  logic [15:0] dac0_q, dac0_d, dac1_q, dac1_d;
  logic        dac_update_q, dac_update_d;
  logic [6:0]  reg_addr_q, reg_addr_d;
  logic [7:0]  reg_data_q, reg_data_d;
  logic        reg_valid_q, reg_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        commit0, commit1, clean;

  assign instr_nx = {instr_q[6:0], sdio0};
  assign shift_nx = {shift_q[13:0], sdio1, sdio0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= WAIT_CS;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_CS: if (cs_hi) state_d = IDLE;
      IDLE:    if (cs_fall) state_d = INSTR;
      INSTR: begin
        if (sclk_rise && bit_cnt_q == 3'd7) begin
          if (instr_nx[7])                   state_d = IGNORE;
          else if (instr_nx[6:0] == DAC_ADDR) state_d = DATA_DAC;
          else                               state_d = DATA_REG;
        end
      end
      default: ;
    endcase
    if (cs_rise) state_d = IDLE;
  end

  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    instr_d       = instr_q;
    shift_d       = shift_q;
    stage0_d      = stage0_q;
    stage1_d      = stage1_q;
    reg_addr_d    = reg_addr_q;
    reg_data_d    = reg_data_q;
    reg_valid_d   = 1'b0;
    frame_err_d   = 1'b0;
    frame_count_d = frame_count_q;
    commit0       = 1'b0;
    commit1       = 1'b0;
    clean         = (word_cnt_q != 2'd0) && (bit_cnt_q == 3'd0);
    unique case (state_q)
      IDLE: begin
        bit_cnt_d  = 3'd0;
        word_cnt_d = 2'd0;
      end
      INSTR: begin
        if (sclk_rise) begin
          instr_d   = instr_nx;
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (cs_rise) frame_err_d = 1'b1;
      end
      DATA_DAC: begin
        if (sclk_rise) begin
          shift_d   = shift_nx;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (word_cnt_q == 2'd0) stage0_d = shift_nx;
            if (word_cnt_q == 2'd1) stage1_d = shift_nx;
            if (word_cnt_q != 2'd3) word_cnt_d = word_cnt_q + 2'd1;
          end
        end
        if (cs_rise) begin
          frame_err_d = ~clean;
          commit0     = clean;
          commit1     = clean && (word_cnt_q >= 2'd2);
          if (clean) frame_count_d = frame_count_q + 16'd1;
        end
      end
      DATA_REG: begin
        if (sclk_rise) begin
          shift_d   = shift_nx;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd3) begin
            bit_cnt_d   = 3'd0;
            reg_data_d  = shift_nx[7:0];
            reg_addr_d  = (word_cnt_q == 2'd0) ? instr_q[6:0]
                                               : reg_addr_q + 7'd1;
            reg_valid_d = 1'b1;
            if (word_cnt_q != 2'd3) word_cnt_d = word_cnt_q + 2'd1;
          end
        end
        if (cs_rise) begin
          frame_err_d = ~clean;
          if (clean) frame_count_d = frame_count_q + 16'd1;
        end
      end
      default: ;
    endcase
    // a commit landing with ldac fall is forwarded straight to the outputs
    shadow0_d    = commit0 ? stage0_q : shadow0_q;
    shadow1_d    = commit1 ? stage1_q : shadow1_q;
    dac0_d       = ldac_fall ? shadow0_d : dac0_q;
    dac1_d       = ldac_fall ? shadow1_d : dac1_q;
    dac_update_d = ldac_fall;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      instr_q       <= '0;
      shift_q       <= '0;
      stage0_q      <= '0;
      stage1_q      <= '0;
      shadow0_q     <= '0;
      shadow1_q     <= '0;
      dac0_q        <= '0;
      dac1_q        <= '0;
      dac_update_q  <= 1'b0;
      reg_addr_q    <= '0;
      reg_data_q    <= '0;
      reg_valid_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      instr_q       <= instr_d;
      shift_q       <= shift_d;
      stage0_q      <= stage0_d;
      stage1_q      <= stage1_d;
      shadow0_q     <= shadow0_d;
      shadow1_q     <= shadow1_d;
      dac0_q        <= dac0_d;
      dac1_q        <= dac1_d;
      dac_update_q  <= dac_update_d;
      reg_addr_q    <= reg_addr_d;
      reg_data_q    <= reg_data_d;
      reg_valid_q   <= reg_valid_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign bus.dac_0       = dac0_q;
  assign bus.dac_1       = dac1_q;
  assign bus.dac_update  = dac_update_q;
  assign bus.reg_addr    = reg_addr_q;
  assign bus.reg_data    = reg_data_q;
  assign bus.reg_valid   = reg_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.frame_count = frame_count_q;
endmodule

// File: tb/tb_ad3542_spi_responder.sv
// Bench for ad3542_spi_responder: fixed frame table, random frames against a
// frame-level model, and hand sequences for reset mid-frame and ldac/commit overlap.
module tb_ad3542_spi_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ad3542_spi_responder_if bus();

  ad3542_spi_responder #(.DAC_ADDR(7'h2A), .SYNC_STG(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int upd_cnt = 0;
  logic [14:0] got_q[$];
  logic [14:0] exp_q[$];
  logic [15:0] m_sh0, m_sh1, m_cnt;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.frame_err)  err_cnt++;
      if (bus.dac_update) upd_cnt++;
      if (bus.reg_valid)  got_q.push_back({bus.reg_addr, bus.reg_data});
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_edge(input logic b1, input logic b0);
    bus.spi_sdio1 = b1;
    bus.spi_sdio0 = b0;
    clks(2);
    bus.spi_sclk = 1'b1;
    clks(3);
    bus.spi_sclk = 1'b0;
    clks(1);
  endtask

  task automatic send_body(input logic [7:0] ins, input int nib,
                           input int ned, input logic [63:0] dat);
    for (int i = 0; i < nib; i++) spi_edge(1'b0, ins[7-i]);
    for (int k = 0; k < ned; k++) spi_edge(dat[63-2*k], dat[62-2*k]);
  endtask

  task automatic run_frame(input logic [7:0] ins, input int nib,
                           input int ned, input logic [63:0] dat);
    bus.spi_cs = 1'b0;
    clks(3);
    send_body(ins, nib, ned, dat);
    clks(2);
    bus.spi_cs = 1'b1;
    clks(8);
  endtask

  // frame-level reference: what a write frame of this shape must produce
  task automatic model_frame(input logic [7:0] ins, input int nib, input int ned,
                             input logic [63:0] dat, output bit err);
    int epw, nw;
    bit is_dac;
    err = 1'b0;
    if (nib < 8) begin
      err = 1'b1;
      return;
    end
    if (ins[7]) return;
    is_dac = (ins[6:0] == 7'h2A);
    epw = is_dac ? 8 : 4;
    nw = ned / epw;
    if (!is_dac)
      for (int k = 0; k < nw; k++)
        exp_q.push_back({7'(ins[6:0] + k), dat[63-8*k -: 8]});
    if (nw == 0 || (ned % epw) != 0) begin
      err = 1'b1;
      return;
    end
    m_cnt = m_cnt + 16'd1;
    if (is_dac) begin
      m_sh0 = dat[63:48];
      if (nw >= 2) m_sh1 = dat[47:32];
    end
  endtask

  task automatic cmp_events();
    chk("reg_events", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("reg_event", got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_frame(input logic [7:0] ins, input int nib, input int ned,
                          input logic [63:0] dat, output int derr,
                          output logic [14:0] last);
    int e0;
    bit merr;
    e0 = err_cnt;
    run_frame(ins, nib, ned, dat);
    model_frame(ins, nib, ned, dat, merr);
    derr = err_cnt - e0;
    last = '0;
    if (got_q.size() > 0) last = got_q[$];
    chk("frame_err", derr, merr);
    chk("frame_count", bus.frame_count, m_cnt);
    cmp_events();
  endtask

  task automatic do_ldac();
    int u0;
    u0 = upd_cnt;
    bus.ldac = 1'b0;
    clks(4);
    bus.ldac = 1'b1;
    clks(6);
    chk("dac_update", upd_cnt - u0, 1);
    chk("dac_0", bus.dac_0, m_sh0);
    chk("dac_1", bus.dac_1, m_sh1);
  endtask

  typedef struct {
    logic [7:0]  ins;
    int          nib;
    int          ned;
    logic [63:0] dat;
    int          err;
    logic [15:0] cnt;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [14:0] last;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int derr, e0, u0;
    logic [14:0] last;
    logic [7:0] ins;
    int nib, ned, r;

    tbl[0] = '{8'h2A, 8, 16, 64'h8000_07FF_0000_0000, 0, 16'd1, 16'h8000, 16'h07FF, 15'h0};
    tbl[1] = '{8'h05, 8, 8,  64'hA53C_0000_0000_0000, 0, 16'd2, 16'h8000, 16'h07FF, {7'h06, 8'h3C}};
    tbl[2] = '{8'h2A, 8, 5,  64'hFFFF_FFFF_0000_0000, 1, 16'd2, 16'h8000, 16'h07FF, 15'h0};
    tbl[3] = '{8'hAA, 8, 16, 64'h1234_5678_0000_0000, 0, 16'd2, 16'h8000, 16'h07FF, 15'h0};
    tbl[4] = '{8'h2A, 8, 8,  64'h1111_0000_0000_0000, 0, 16'd3, 16'h1111, 16'h07FF, 15'h0};
    tbl[5] = '{8'h2A, 8, 0,  64'h0,                   1, 16'd3, 16'h1111, 16'h07FF, 15'h0};
    tbl[6] = '{8'h2A, 8, 24, 64'h2222_3333_4444_0000, 0, 16'd4, 16'h2222, 16'h3333, 15'h0};
    tbl[7] = '{8'h10, 8, 6,  64'hC3F0_0000_0000_0000, 1, 16'd4, 16'h2222, 16'h3333, {7'h10, 8'hC3}};
    tbl[8] = '{8'h2A, 5, 0,  64'h0,                   1, 16'd4, 16'h2222, 16'h3333, 15'h0};
    tbl[9] = '{8'h7F, 8, 8,  64'h5AC3_0000_0000_0000, 0, 16'd5, 16'h2222, 16'h3333, {7'h00, 8'hC3}};

    bus.spi_sclk  = 1'b0;
    bus.spi_cs    = 1'b1;
    bus.spi_sdio0 = 1'b0;
    bus.spi_sdio1 = 1'b0;
    bus.ldac      = 1'b1;
    m_sh0 = '0;
    m_sh1 = '0;
    m_cnt = '0;
    reset = 1'b1;
    clks(3);
    reset = 1'b0;
    clks(4);
    chk("rst_dac_0", bus.dac_0, 16'h0);
    chk("rst_dac_1", bus.dac_1, 16'h0);
    chk("rst_reg_addr", bus.reg_addr, 7'h0);
    chk("rst_reg_data", bus.reg_data, 8'h0);
    chk("rst_frame_count", bus.frame_count, 16'h0);
    chk("rst_pulses", {bus.dac_update, bus.reg_valid, bus.frame_err}, 3'b000);

    for (int i = 0; i < 10; i++) begin
      do_frame(tbl[i].ins, tbl[i].nib, tbl[i].ned, tbl[i].dat, derr, last);
      do_ldac();
      chk("tbl_err", derr, tbl[i].err);
      chk("tbl_count", bus.frame_count, tbl[i].cnt);
      chk("tbl_dac_0", bus.dac_0, tbl[i].d0);
      chk("tbl_dac_1", bus.dac_1, tbl[i].d1);
      chk("tbl_last_reg", last, tbl[i].last);
    end

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      ins = 8'h2A;
      else if (r < 7) ins = {1'b0, 7'($urandom)};
      else            ins = {1'b1, 7'($urandom)};
      nib = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : 8;
      ned = (nib < 8) ? 0 : $urandom_range(0, 20);
      do_frame(ins, nib, ned, {$urandom, $urandom}, derr, last);
      do_ldac();
    end

    // reset lands mid-DATA_DAC and is released with cs still low
    e0 = err_cnt;
    bus.spi_cs = 1'b0;
    clks(3);
    send_body(8'h2A, 8, 4, 64'hABCD_EF01_0000_0000);
    reset = 1'b1;
    clks(3);
    chk("midrst_dac_0", bus.dac_0, 16'h0);
    chk("midrst_count", bus.frame_count, 16'h0);
    reset = 1'b0;
    clks(2);
    for (int k = 4; k < 16; k++) spi_edge(k[0], ~k[0]);
    clks(2);
    bus.spi_cs = 1'b1;
    clks(8);
    m_sh0 = '0;
    m_sh1 = '0;
    m_cnt = '0;
    got_q.delete();
    chk("midrst_err", err_cnt - e0, 0);
    chk("midrst_count_after", bus.frame_count, 16'h0);
    do_ldac();
    do_frame(8'h2A, 8, 16, {$urandom, $urandom}, derr, last);
    do_ldac();

    // ldac fall arriving together with the commit of FFFF/0FFF
    do_frame(8'h2A, 8, 16, 64'h1234_5678_0000_0000, derr, last);
    do_ldac();
    e0 = err_cnt;
    u0 = upd_cnt;
    bus.spi_cs = 1'b0;
    clks(3);
    send_body(8'h2A, 8, 16, 64'hFFFF_0FFF_0000_0000);
    clks(2);
    bus.spi_cs = 1'b1;
    bus.ldac = 1'b0;
    clks(1);
    chk("coinc_before", bus.dac_0, 16'h1234);
    clks(1);
    chk("coinc_dac_0", bus.dac_0, 16'hFFFF);
    chk("coinc_dac_1", bus.dac_1, 16'h0FFF);
    chk("coinc_update", bus.dac_update, 1'b1);
    clks(3);
    bus.ldac = 1'b1;
    clks(6);
    m_cnt = m_cnt + 16'd1;
    chk("coinc_upd_cnt", upd_cnt - u0, 1);
    chk("coinc_err", err_cnt - e0, 0);
    chk("coinc_count", bus.frame_count, m_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
